rsa4k_stream_io: RTL and testbench
==================================

# rsa4k_stream_io

Streaming front/back end for the `rsa4k` modular-exponentiation core. Accepts message, exponent and modulus as a 32-bit valid/ready word stream and assembles the three 4096-bit operands. Sequences the core's `reset`/`go`/`done` protocol, captures `cypher`, and streams the result back out as 32-bit words. Sits between the system bus/DMA and `rsa4k`; both the block and `rsa4k` are instantiated side by side in the crypto top.

## Interface
- `WIDTH`, 4096: operand/result width in bits.
- `WORD`, 32: stream word width in bits; WIDTH must be a multiple of WORD.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept an input word.
- `in_data` in WORD: input word.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: downstream accepts the result word.
- `out_data` out WORD: result word.
- `out_last` out 1: high on the final result word (word NW-1).
- `busy` out 1: high in every state except IDLE.
- `core_reset` out 1: active-high reset pulse to `rsa4k`.
- `core_go` out 1: `rsa4k` start, level.
- `core_message`, `core_exponent`, `core_modulus` out WIDTH: operand registers.
- `core_cypher` in WIDTH: core result.
- `core_done` in 1: core completion, level.

## Operation
- NW = WIDTH/WORD (128). The input sequence is 3·NW words: message, then exponent, then modulus, each least-significant word first.
- Word index counter `idx` is ceil(log2(3·NW)) bits. `idx / NW` selects the operand and `idx % NW` selects the word slot. Each accepted beat writes exactly that slot.
- States:
  - IDLE: `in_ready`=1. On the first handshake, write slot 0, set `idx`=1 and go to LOAD.
  - LOAD: `in_ready`=1. Each handshake writes its slot and increments `idx`. The handshake at `idx`=3·NW-1 goes to CLR.
  - CLR (1 cycle): `core_reset`=1, `core_go`=0. Then go to RUN.
  - RUN: `core_go`=1. When `core_done`=1 is sampled, latch `core_cypher` into the result register, drive `core_go`=0, clear `idx`, and go to UNLOAD.
  - UNLOAD: `out_valid`=1 and `out_data` = result[WORD-1:0]. On each handshake, shift the result right by WORD and increment `idx`. `out_last` = (`idx`==NW-1). The last handshake returns to IDLE.
- `in_ready`=0 in CLR, RUN and UNLOAD. Words offered in those states are not consumed.
- Operand registers hold their values until overwritten by the next load. `core_*` operands are driven directly from them.
- No checking of operand values (for example a zero modulus); results are whatever the core returns.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `core_reset`=0, `core_go`=0, `idx`=0, operand and result registers 0, state IDLE.
- Asserting reset at any time, including mid-LOAD, RUN or UNLOAD, forces the reset values immediately. The partial load is discarded, and the next accepted word is message word 0.
- Throughput is one input word per cycle when `in_valid` is held high, so the load takes 3·NW cycles minimum.
- The first `core_go`=1 occurs 2 cycles after the final input handshake (CLR, then RUN).
- `out_valid` rises 1 cycle after `core_done` is sampled.
- Under backpressure (`out_ready`=0), `out_data` and `out_last` are held stable, with no skipped or duplicated words.
- `core_done` is ignored outside RUN. `out_ready` is ignored outside UNLOAD.

## Structure
- Shared package `rsa4k_pkg` holds:
  - the WIDTH and WORD defaults;
  - the NW and 3·NW localparams;
  - the state enum (IDLE, LOAD, CLR, RUN, UNLOAD).
- No sub-module is needed; this is a single FSM plus datapath registers.
- Optional sub-module `rsa4k_res_shifter` holds the result register with its shift-out and `out_last` logic.
- `rsa4k` itself is not instantiated here.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, release → all outputs at their reset values and `in_ready`=1.
- Basic op: stream m=8, e=13, n=77 (384 words) → `core_go` rises 2 cycles after the last beat. Result words: word0=0x00000032, words 1..127=0, `out_last` only on the 128th.
- Round trip: feed that result back with e=37, n=77 → word0=0x00000008, all other words 0.
- Backpressure: random `in_valid` gaps, and `out_ready` low for 10 cycles mid-unload → same values as the basic op, with `out_data` stable while stalled.
- Flow control: offer words while busy in RUN/UNLOAD → `in_ready`=0, the words are not consumed, and the operands are unchanged.
- Mid-op reset: assert reset after 200 input beats, then reload m=8, e=13, n=77 → result word0=0x32.

Source files
------------

// File: rtl/rsa4k_pkg.sv
// Shared definitions for the rsa4k stream front/back end.
//   WIDTH_DEF / WORD_DEF : default operand and stream word widths
//   NW / NW3             : words per operand and words per full load
//   state_e              : sequencing states of rsa4k_stream_io
package rsa4k_pkg;
  localparam int WIDTH_DEF = 4096;
  localparam int WORD_DEF  = 32;
  localparam int NW        = WIDTH_DEF / WORD_DEF;
  localparam int NW3       = 3 * NW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    RUN,
    UNLOAD
  } state_e;
endpackage

// File: rtl/rsa4k_res_shifter.sv
// Result register for rsa4k_stream_io.
//   load/load_data : capture the core result
//   shift          : drop the low word after an output handshake
//   active/idx     : unload in progress and current word index
//   out_data       : low word of the result register
//   out_last       : current word is the final one (word NW-1)
module rsa4k_res_shifter #(
  parameter int WIDTH = 4096,
  parameter int WORD  = 32,
  parameter int IDXW  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             active,
  input  logic [IDXW-1:0]  idx,
  output logic [WORD-1:0]  out_data,
  output logic             out_last
);
  localparam int LNW = WIDTH / WORD;

  logic [WIDTH-1:0] res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     res <= '0;
    else if (load)  res <= load_data;
    else if (shift) res <= res >> WORD;
  end

  assign out_data = res[WORD-1:0];
  assign out_last = active && (idx == IDXW'(LNW - 1));
endmodule

// File: rtl/rsa4k_stream_io.sv
// Stream front/back end for the rsa4k modexp core.
//   clk, reset (async, active low)
//   in_valid/in_ready/in_data    : 3*NW-word operand stream (msg, exp, mod; LS word first)
//   out_valid/out_ready/out_data : NW-word result stream, out_last on final word
//   busy                         : not IDLE
//   core_reset/core_go/core_done : rsa4k control handshake
//   core_message/exponent/modulus: operand registers; core_cypher: core result
// WIDTH/WORD must give at least two words per operand.
module rsa4k_stream_io
  import rsa4k_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             busy,
  output logic             core_reset,
  output logic             core_go,
  output logic [WIDTH-1:0] core_message,
  output logic [WIDTH-1:0] core_exponent,
  output logic [WIDTH-1:0] core_modulus,
  input  logic [WIDTH-1:0] core_cypher,
  input  logic             core_done
);
  localparam int LNW  = WIDTH / WORD;
  localparam int LNW3 = 3 * LNW;
  localparam int IDXW = $clog2(LNW3);
  localparam int SLW  = $clog2(LNW);

  state_e            state, state_n;
  logic [IDXW-1:0]   idx, idx_n;
  logic              res_load, res_shift;
  logic [1:0]        op_sel;
  logic [SLW-1:0]    slot;

  logic [LNW-1:0][WORD-1:0] msg_q, exp_q, mod_q;

  // idx walks all three operands; quotient picks the operand, remainder the word
  assign op_sel = 2'(idx / IDXW'(LNW));
  assign slot   = SLW'(idx % IDXW'(LNW));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_reset = 1'b0;
    core_go    = 1'b0;
    res_load   = 1'b0;
    res_shift  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_n   = IDXW'(1);
          state_n = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_n = idx + IDXW'(1);
          if (idx == IDXW'(LNW3 - 1)) state_n = CLR;
        end
      end
      CLR: begin
        core_reset = 1'b1;
        state_n    = RUN;
      end
      RUN: begin
        core_go = 1'b1;
        if (core_done) begin
          res_load = 1'b1;
          idx_n    = '0;
          state_n  = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          res_shift = 1'b1;
          idx_n     = idx + IDXW'(1);
          if (idx == IDXW'(LNW - 1)) begin
            idx_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // in IDLE idx is always 0, so the first beat lands in message slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
    end else if (in_valid && in_ready) begin
      case (op_sel)
        2'd0:    msg_q[slot] <= in_data;
        2'd1:    exp_q[slot] <= in_data;
        default: mod_q[slot] <= in_data;
      endcase
    end
  end

  assign core_message  = msg_q;
  assign core_exponent = exp_q;
  assign core_modulus  = mod_q;

  rsa4k_res_shifter #(
    .WIDTH(WIDTH),
    .WORD (WORD),
    .IDXW (IDXW)
  ) u_res (
    .clk      (clk),
    .reset    (reset),
    .load     (res_load),
    .load_data(core_cypher),
    .shift    (res_shift),
    .active   (state == UNLOAD),
    .idx      (idx),
    .out_data (out_data),
    .out_last (out_last)
  );
endmodule

// File: tb/tb_rsa4k_stream_io.sv
module tb_rsa4k_stream_io;
  import rsa4k_pkg::*;

  localparam int W = WIDTH_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [31:0]   in_data;
  logic          out_valid, out_ready, out_last, busy;
  logic [31:0]   out_data;
  logic          core_reset, core_go, core_done;
  logic [W-1:0]  core_message, core_exponent, core_modulus, core_cypher;

  int checks = 0;
  int errors = 0;

  int core_lat, core_mode, core_cnt;

  logic [W-1:0]  tm, te, tn;
  logic [31:0]   expw [NW];

  typedef struct {
    logic [31:0] m, e, n, w0;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  rsa4k_stream_io dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .core_reset(core_reset), .core_go(core_go),
    .core_message(core_message), .core_exponent(core_exponent), .core_modulus(core_modulus),
    .core_cypher(core_cypher), .core_done(core_done)
  );

  function automatic logic [31:0] modexp(logic [31:0] b, logic [31:0] e, logic [31:0] n);
    longint unsigned r, x, nn;
    if (n == 0) return 32'd0;
    nn = 64'(n);
    r  = 1 % nn;
    x  = 64'(b) % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return 32'(r);
  endfunction

  // Stand-in for rsa4k: mode 0 does a small modexp on the low words,
  // mode 1 returns msg^exp^mod so every operand bit reaches the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done   <= 1'b0;
      core_cnt    <= 0;
      core_cypher <= '0;
    end else if (core_reset) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (core_go && !core_done) begin
      if (core_cnt >= core_lat) begin
        core_done <= 1'b1;
        if (core_mode == 0)
          core_cypher <= W'(modexp(core_message[31:0], core_exponent[31:0], core_modulus[31:0]));
        else
          core_cypher <= core_message ^ core_exponent ^ core_modulus;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int cyc = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic send_beats(input int count, input int gapmax);
    logic [31:0] w;
    for (int i = 0; i < count; i++) begin
      case (i / NW)
        0:       w = tm[(i % NW)*32 +: 32];
        1:       w = te[(i % NW)*32 +: 32];
        default: w = tn[(i % NW)*32 +: 32];
      endcase
      send(w, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    end
  endtask

  // rdymode: 0 always ready, 1 random ready, 2 ten-cycle stall at word 64
  task automatic unload(input int rdymode);
    int i = 0, cyc = 0, stall = 0;
    while (i < NW && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (i >= NW - 2) in_valid = 1'b0;
      case (rdymode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (i == 64 && stall < 10) begin
            out_ready = 1'b0;
            stall++;
          end else out_ready = 1'b1;
        end
      endcase
      if (out_valid) begin
        chk($sformatf("out_word%0d", i), {31'd0, out_last, out_data}, {31'd0, (i == NW - 1), expw[i]});
        if (out_ready) i++;
      end
    end
    if (i < NW) chk("unload_timeout", 64'(i), 64'(NW));
  endtask

  task automatic run_job(input int gapmax, input int rdymode, input bit flow);
    int cyc = 0;
    send_beats(NW3, gapmax);
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_cycle", {core_reset, core_go, in_ready}, 3'b100);
    chk("op_msg", 64'(core_message == tm), 1);
    chk("op_exp", 64'(core_exponent == te), 1);
    chk("op_mod", 64'(core_modulus == tn), 1);
    @(negedge clk);
    chk("go_2cyc", {core_reset, core_go, busy}, 3'b011);
    if (flow) begin
      for (int k = 0; k < 10; k++) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("ready_run", 64'(in_ready), 0);
        @(negedge clk);
      end
    end
    while (!core_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(core_done), 1);
    chk("valid_pre", 64'(out_valid), 0);
    @(negedge clk);
    chk("valid_1cyc", {out_valid, core_go}, 2'b10);
    if (flow) chk("ready_unload", 64'(in_ready), 0);
    unload(rdymode);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after", {busy, out_valid, out_last, in_ready}, 4'b0001);
    if (flow) begin
      chk("keep_msg", 64'(core_message == tm), 1);
      chk("keep_exp", 64'(core_exponent == te), 1);
      chk("keep_mod", 64'(core_modulus == tn), 1);
    end
  endtask

  task automatic set_small(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                           input logic [31:0] w0);
    tm = W'(m);
    te = W'(e);
    tn = W'(n);
    for (int k = 0; k < NW; k++) expw[k] = 32'd0;
    expw[0] = w0;
  endtask

  initial begin
    vecs[0] = '{m: 32'd8,     e: 32'd13, n: 32'd77,   w0: 32'h32};
    vecs[1] = '{m: 32'h32,    e: 32'd37, n: 32'd77,   w0: 32'h08};
    vecs[2] = '{m: 32'd3,     e: 32'd5,  n: 32'd7,    w0: 32'd5};
    vecs[3] = '{m: 32'd2,     e: 32'd10, n: 32'd1000, w0: 32'd24};
    vecs[4] = '{m: 32'd5,     e: 32'd0,  n: 32'd13,   w0: 32'd1};
    vecs[5] = '{m: 32'd7,     e: 32'd3,  n: 32'd100,  w0: 32'd43};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    core_lat = 5; core_mode = 0;

    repeat (3) @(negedge clk);
    chk("rst_hold", {in_ready, out_valid, out_last, busy, core_reset, core_go}, 6'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", {in_ready, out_valid, out_last, busy, core_reset, core_go}, 6'b100000);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_ops", 64'(core_message == '0 && core_exponent == '0 && core_modulus == '0), 1);

    // directed vectors: basic op, round trip and a few more small modexps
    for (int v = 0; v < 6; v++) begin
      set_small(vecs[v].m, vecs[v].e, vecs[v].n, vecs[v].w0);
      run_job(0, 0, 1'b0);
    end

    // input gaps plus a ten-cycle output stall
    set_small(32'd8, 32'd13, 32'd77, 32'h32);
    run_job(3, 2, 1'b0);

    // words offered while busy must not be consumed
    core_lat = 40;
    set_small(32'd8, 32'd13, 32'd77, 32'h32);
    run_job(0, 0, 1'b1);
    core_lat = 5;

    // full-width random operands, random gaps and backpressure
    core_mode = 1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NW; k++) begin
        tm[k*32 +: 32] = $urandom;
        te[k*32 +: 32] = $urandom;
        tn[k*32 +: 32] = $urandom;
      end
      for (int k = 0; k < NW; k++) expw[k] = tm[k*32 +: 32] ^ te[k*32 +: 32] ^ tn[k*32 +: 32];
      core_lat = int'($urandom_range(2, 12));
      run_job(2, 1, 1'b0);
    end
    core_mode = 0;
    core_lat = 5;

    // reset mid-load discards the partial operands
    tm = {W{1'b1}}; te = {W{1'b1}}; tn = {W{1'b1}};
    send_beats(200, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {in_ready, out_valid, busy, core_reset, core_go}, 5'b10000);
    chk("mid_rst_ops", 64'(core_message == '0 && core_exponent == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    set_small(32'd8, 32'd13, 32'd77, 32'h32);
    run_job(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
